mem_req_ctrl: RTL and testbench

//   Request front-end sitting directly upstream of the 16x32 memory. Accepts

---
 rtl/mem_req_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request front-end for the 16x32 memory: FIFO-buffered valid/ready requests, one memory op per ISSUE cycle.
// Strobes appear 2 cycles after a request is presented to an idle block; only one read is in flight, and req_ready drops when the FIFO is full.

module mem_req_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Fullness comes from the registered count only, so a same-cycle pop never admits a push.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_req_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              En,
    output logic              Rw_en,
    output logic              Rr_en,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Data_out,
    input  logic              Valid_out,
    output logic              busy
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    req_t              req_in, head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              iss_wr, iss_wr_nxt;
    logic [TW-1:0]     timer, timer_nxt, timer_inc;
    logic              en_nxt, rw_nxt, rr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    assign req_in    = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign timer_inc = timer + TW'(1);

    mem_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_valid),
        .push_dat (req_in),
        .pop      (fifo_pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            iss_wr    <= 1'b0;
            timer     <= '0;
            En        <= 1'b0;
            Rw_en     <= 1'b0;
            Rr_en     <= 1'b0;
            Address   <= '0;
            Data_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            iss_wr    <= iss_wr_nxt;
            timer     <= timer_nxt;
            En        <= en_nxt;
            Rw_en     <= rw_nxt;
            Rr_en     <= rr_nxt;
            Address   <= addr_nxt;
            Data_in   <= din_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        iss_wr_nxt    = iss_wr;
        timer_nxt     = timer;
        en_nxt        = 1'b0;
        rw_nxt        = 1'b0;
        rr_nxt        = 1'b0;
        addr_nxt      = Address;
        din_nxt       = Data_in;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        fifo_pop      = 1'b0;

        case (state)
            IDLE: begin
                fifo_pop = !fifo_empty;
            end
            ISSUE: begin
                if (iss_wr) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = '0;
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                timer_nxt = timer_inc;
                // Data arriving in the expiry cycle takes priority over the timeout.
                if (Valid_out) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = Data_out;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = RESP;
                end else if (timer_inc == TW'(RD_TIMEOUT)) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A pop loads the strobes directly so they are visible during the ISSUE cycle itself.
        if (fifo_pop) begin
            state_nxt  = ISSUE;
            iss_wr_nxt = head.wr;
            en_nxt     = 1'b1;
            rw_nxt     = head.wr;
            rr_nxt     = !head.wr;
            addr_nxt   = head.addr;
            din_nxt    = head.wr ? head.wdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a scoreboard of expected memory strobes and read responses.
module tb_mem_req_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        En, Rw_en, Rr_en;
    logic [3:0]  Address;
    logic [31:0] Data_in;
    logic [31:0] Data_out = '0;
    logic        Valid_out = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [37:0] exp_iss [$];
    logic [32:0] exp_rsp [$];
    logic [37:0] mon_e;
    logic [32:0] mon_r;

    mem_req_ctrl #(
        .ADDR_W     (4),
        .DATA_W     (32),
        .DEPTH      (4),
        .RD_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .En        (En),
        .Rw_en     (Rw_en),
        .Rr_en     (Rr_en),
        .Address   (Address),
        .Data_in   (Data_in),
        .Data_out  (Data_out),
        .Valid_out (Valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic wr, input logic [3:0] addr, input logic [31:0] data, input logic acc);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        chk("req_ready", 64'(req_ready), 64'(acc));
        if (acc) begin
            exp_iss.push_back({wr, ~wr, addr, (wr ? data : 32'h0)});
        end
        tick(1);
        req_valid = 1'b0;
    endtask

    // Scoreboard side: an all-ones expectation (Rw_en and Rr_en together) marks an unexpected strobe.
    always @(negedge clk) begin
        if (En) begin
            mon_e = (exp_iss.size() != 0) ? exp_iss.pop_front() : '1;
            chk("issue", 64'({Rw_en, Rr_en, Address, Data_in}), 64'(mon_e));
        end
        if (rsp_valid && rsp_ready) begin
            mon_r = (exp_rsp.size() != 0) ? exp_rsp.pop_front() : '1;
            chk("response", 64'({rsp_err, rsp_rdata}), 64'(mon_r));
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_strobes"}, 64'({En, Rw_en, Rr_en, Address, Data_in}), 64'(0));
        chk({tag, "_rsp"}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        // 1: reset state, then reset again while idle
        tick(2);
        chk_idle_outputs("por");
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        chk_idle_outputs("idle_rst");
        tick(1);
        rst = 1'b0;
        tick(1);

        // 2: single write, strobe pulse two cycles after presentation
        send(1'b1, 4'd3, 32'hDEADBEEF, 1'b1);
        chk("wr_pre_en", 64'(En), 64'(0));
        chk("wr_busy", 64'(busy), 64'(1));
        tick(1);
        chk("wr_en", 64'({En, Rw_en, Rr_en}), 64'(3'b110));
        tick(1);
        chk("wr_en_drop", 64'({En, Rw_en, rsp_valid}), 64'(0));

        // 3: read with data two cycles after Rr_en, consumer stalls 3 cycles
        exp_rsp.push_back({1'b0, 32'hDEADBEEF});
        send(1'b0, 4'd3, 32'h0, 1'b1);
        tick(1);
        chk("rd_strobe", 64'({En, Rw_en, Rr_en, Data_in}), 64'({3'b101, 32'h0}));
        tick(2);
        Valid_out = 1'b1;
        Data_out  = 32'hDEADBEEF;
        tick(1);
        Valid_out = 1'b0;
        Data_out  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_hold", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b10, 32'hDEADBEEF}));
            tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("rd_rsp_drop", 64'(rsp_valid), 64'(0));

        // 4: timed-out read while four writes fill the FIFO behind it
        exp_rsp.push_back({1'b1, 32'h0});
        send(1'b0, 4'd5, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 4'(8 + i), 32'h1000_0000 + 32'(i), 1'b1);
        end
        send(1'b1, 4'd15, 32'hBAD0BAD0, 1'b0);
        chk("full_ready", 64'(req_ready), 64'(0));
        tick(4);
        chk("to_not_yet", 64'(rsp_valid), 64'(0));
        tick(1);
        chk("to_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b11, 32'h0}));
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_wr", 64'({En, Rw_en}), 64'(2'b11));
            tick(1);
        end
        chk("b2b_done", 64'({En, busy}), 64'(0));

        // 5: Valid_out in the expiry cycle wins over the timeout
        exp_rsp.push_back({1'b0, 32'hCAFEF00D});
        send(1'b0, 4'd7, 32'h0, 1'b1);
        tick(9);
        chk("exp_cycle_no_rsp", 64'(rsp_valid), 64'(0));
        Valid_out = 1'b1;
        Data_out  = 32'hCAFEF00D;
        tick(1);
        Valid_out = 1'b0;
        Data_out  = 32'h0;
        chk("exp_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({2'b10, 32'hCAFEF00D}));
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;

        // 6: reset during WAIT_RD with two writes queued
        send(1'b0, 4'd2, 32'h0, 1'b1);
        send(1'b1, 4'd4, 32'h4444_4444, 1'b1);
        send(1'b1, 4'd5, 32'h5555_5555, 1'b1);
        tick(1);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk_idle_outputs("wait_rst");
        exp_iss.delete();
        exp_rsp.delete();
        tick(2);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        Valid_out = 1'b1;
        Data_out  = 32'h0000_0123;
        tick(2);
        Valid_out = 1'b0;
        Data_out  = 32'h0;
        tick(8);
        chk("post_rst_quiet", 64'({rsp_valid, busy, En}), 64'(0));
        rsp_ready = 1'b0;

        chk("iss_q_drained", 64'(exp_iss.size()), 64'(0));
        chk("rsp_q_drained", 64'(exp_rsp.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
